// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, stage indices, FSM encoding and hold/flush patterns
package pipe_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int MC_CYCLES_DEF = 32;
  localparam int PC = 0;
  localparam int IF_ID = 1;
  localparam int ID_EX = 2;
  localparam int EX_MEM = 3;
  localparam int MEM_WB = 4;
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1, MC_DONE = 2'd2} state_t;
  localparam logic [4:0] B_PC = 5'd1 << PC;
  localparam logic [4:0] B_IF_ID = 5'd1 << IF_ID;
  localparam logic [4:0] B_ID_EX = 5'd1 << ID_EX;
  localparam logic [4:0] B_EX_MEM = 5'd1 << EX_MEM;
  localparam logic [4:0] B_MEM_WB = 5'd1 << MEM_WB;
  localparam logic [4:0] STALL_MEM = B_PC | B_IF_ID | B_ID_EX | B_EX_MEM;
  localparam logic [4:0] STALL_MC = B_PC | B_IF_ID | B_ID_EX;
  localparam logic [4:0] STALL_LU = B_PC | B_IF_ID;
  localparam logic [4:0] FLUSH_JMP = B_IF_ID | B_ID_EX;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk_i)
    if (rst_i) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard stall/flush, jump redirect and multi-cycle EX sequencing
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = MC_CYCLES_DEF,
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_wait_i,
  input  logic              ex_mc_start_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              ld_use_i,
  output logic [4:0]        stall_o,
  output logic [4:0]        flush_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              mc_done_o,
  output logic [31:0]       stall_cnt_o,
  output logic [15:0]       jump_cnt_o
);
  state_t state, state_n;
  logic [7:0] mc_cnt, mc_cnt_n;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= RUN;
      mc_cnt <= '0;
    end else begin
      state <= state_n;
      mc_cnt <= mc_cnt_n;
    end
  always_comb begin
    state_n = state;
    mc_cnt_n = mc_cnt;
    stall_o = '0;
    flush_o = '0;
    jump_o = 1'b0;
    jump_addr_o = '0;
    mc_done_o = 1'b0;
    if (rst_i) flush_o = '1;
    else begin
      mc_done_o = state == MC_DONE;
      if (state == MC_WAIT) begin
        mc_cnt_n = mc_cnt - 8'd1;
        if (mc_cnt == 8'd0) state_n = MC_DONE;
      end
      if (state == MC_DONE && !mem_wait_i) state_n = RUN;
      if (mem_wait_i) begin
        stall_o = STALL_MEM;
        flush_o = B_MEM_WB;
      end else if (state == MC_WAIT) begin
        stall_o = STALL_MC;
        flush_o = B_EX_MEM;
      end else if (state == RUN) begin
        if (ex_jump_i) begin
          flush_o = FLUSH_JMP;
          jump_o = 1'b1;
          jump_addr_o = ex_jump_addr_i;
        end else if (ex_mc_start_i) begin
          stall_o = STALL_MC;
          flush_o = B_EX_MEM;
          state_n = MC_WAIT;
          mc_cnt_n = 8'(MC_CYCLES - 2);
        end else if (ld_use_i) begin
          stall_o = STALL_LU;
          flush_o = B_ID_EX;
        end
      end
    end
  end
  pipe_perf_cnt #(.W(32)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc(stall_o[PC]), .cnt(stall_cnt_o)
  );
  pipe_perf_cnt #(.W(16)) u_jump_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc(jump_o), .cnt(jump_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table plus multi-cycle sequences, scoreboard-checked
module tb_pipe_ctrl;
  localparam int MC = 32;
  typedef struct packed {
    logic rst, mw, ms, j;
    logic [31:0] a;
    logic lu;
    logic [4:0] es, ef;
    logic ej;
    logic [31:0] ea;
    logic ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst_i, mem_wait_i, ex_mc_start_i, ex_jump_i, ld_use_i;
  logic [31:0] ex_jump_addr_i;
  logic [4:0] stall_o, flush_o;
  logic jump_o, mc_done_o;
  logic [31:0] jump_addr_o, stall_cnt_o;
  logic [15:0] jump_cnt_o;
  int passed = 0, total = 0;
  logic [31:0] m_stall;
  logic [15:0] m_jump;
  vec_t q[$];
  vec_t tbl[9];
  always #5 clk = ~clk;
  pipe_ctrl #(.MC_CYCLES(MC), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_wait_i(mem_wait_i), .ex_mc_start_i(ex_mc_start_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i), .ld_use_i(ld_use_i),
    .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
    .mc_done_o(mc_done_o), .stall_cnt_o(stall_cnt_o), .jump_cnt_o(jump_cnt_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
  endtask
  function automatic vec_t mk(input logic rst, mw, ms, j, input logic [31:0] a, input logic lu,
                              input logic [4:0] es, ef, input logic ej, input logic [31:0] ea,
                              input logic ed);
    return '{rst, mw, ms, j, a, lu, es, ef, ej, ea, ed};
  endfunction
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    rst_i = v.rst;
    mem_wait_i = v.mw;
    ex_mc_start_i = v.ms;
    ex_jump_i = v.j;
    ex_jump_addr_i = v.a;
    ld_use_i = v.lu;
    q.push_back(v);
    @(negedge clk);
    e = q.pop_front();
    check({tag, ".stall"}, 32'(stall_o), 32'(e.es));
    check({tag, ".flush"}, 32'(flush_o), 32'(e.ef));
    check({tag, ".jump"}, 32'(jump_o), 32'(e.ej));
    check({tag, ".jaddr"}, jump_addr_o, e.ea);
    check({tag, ".done"}, 32'(mc_done_o), 32'(e.ed));
    @(posedge clk);
    if (e.rst) begin
      m_stall = '0;
      m_jump = '0;
    end else begin
      if (e.es[0] && !(&m_stall)) m_stall++;
      if (e.ej && !(&m_jump)) m_jump++;
    end
    #1;
  endtask
  task automatic counters(input string tag);
    @(negedge clk);
    check({tag, ".stall_cnt"}, stall_cnt_o, m_stall);
    check({tag, ".jump_cnt"}, 32'(jump_cnt_o), 32'(m_jump));
    @(posedge clk);
    #1;
  endtask
  task automatic rst_step();
    step(mk(1, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 0, 0, 0), "rst");
  endtask
  task automatic idle(input string tag, input logic ed);
    step(mk(0, 0, 0, 0, 32'h55, 0, 5'b00000, 5'b00000, 0, 0, ed), tag);
  endtask
  initial begin
    m_stall = '0;
    m_jump = '0;
    tbl[0] = mk(1, 0, 0, 0, 32'h0, 0, 5'b00000, 5'b11111, 0, 32'h0, 0);
    tbl[1] = mk(1, 1, 1, 1, 32'h44, 1, 5'b00000, 5'b11111, 0, 32'h0, 0);
    tbl[2] = mk(0, 0, 0, 0, 32'h0, 0, 5'b00000, 5'b00000, 0, 32'h0, 0);
    tbl[3] = mk(0, 0, 0, 1, 32'h100, 0, 5'b00000, 5'b00110, 1, 32'h100, 0);
    tbl[4] = mk(0, 0, 0, 0, 32'h0, 1, 5'b00011, 5'b00100, 0, 32'h0, 0);
    tbl[5] = mk(0, 0, 0, 1, 32'h200, 1, 5'b00000, 5'b00110, 1, 32'h200, 0);
    tbl[6] = mk(0, 1, 1, 1, 32'h300, 1, 5'b01111, 5'b10000, 0, 32'h0, 0);
    tbl[7] = mk(0, 0, 0, 0, 32'h1234, 0, 5'b00000, 5'b00000, 0, 32'h0, 0);
    tbl[8] = mk(0, 0, 0, 1, 32'hdeadbeef, 1, 5'b00000, 5'b00110, 1, 32'hdeadbeef, 0);
    for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("tbl%0d", i));
    counters("tbl");
    rst_step();
    for (int i = 0; i < 4; i++) idle("idle", 0);
    counters("idle");
    rst_step();
    step(mk(0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcA.start");
    for (int i = 1; i < MC; i++)
      step(mk(0, 0, i == 3, i == 5, 32'h80, i == 7, 5'b00111, 5'b01000, 0, 0, 0), "mcA.wait");
    step(mk(0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0, 1), "mcA.done");
    idle("mcA.after", 0);
    counters("mcA");
    check("mcA.stall_cnt_lit", stall_cnt_o, 32'd32);
    rst_step();
    step(mk(0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcB.start");
    for (int i = 1; i < 30; i++) step(mk(0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcB.wait");
    for (int i = 30; i < 36; i++)
      step(mk(0, 1, 0, 1, 32'h9, 1, 5'b01111, 5'b10000, 0, 0, i >= MC), "mcB.memw");
    step(mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 1), "mcB.done");
    step(mk(0, 0, 0, 0, 0, 1, 5'b00011, 5'b00100, 0, 0, 0), "mcB.run");
    counters("mcB");
    rst_step();
    step(mk(0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcC.start");
    for (int i = 1; i < 10; i++) step(mk(0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcC.wait");
    rst_step();
    counters("mcC.rst");
    step(mk(0, 0, 0, 0, 0, 1, 5'b00011, 5'b00100, 0, 0, 0), "mcC.run");
    for (int i = 0; i < MC; i++) idle("mcC.nodone", 0);
    step(mk(0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0), "mcC.restart");
    counters("mcC");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_CYCLES, default 32, is the number of cycles a multi-cycle EX operation occupies EX (legal range 2..255).
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH (32), is the jump target width.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 mem_wait_i  in  1  data memory not ready; the MEM stage must hold.
REQ-006 ex_mc_start_i  in  1  EX has just accepted a multi-cycle op (mul/div).
REQ-007 ex_jump_i  in  1  EX resolved a taken branch or jump this cycle.
REQ-008 ex_jump_addr_i  in  ADDR_W  redirect target.
REQ-009 ld_use_i  in  1  ID detected a load-use hazard that forwarding cannot cover.
REQ-010 stall_o  out  5  hold enables: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
REQ-011 flush_o  out  5  same indexing; a set bit loads NOP/bubble into that register.
REQ-012 jump_o  out  1  PC redirect strobe.
REQ-013 jump_addr_o  out  ADDR_W  redirect target, valid when jump_o=1.
REQ-014 mc_done_o  out  1  multi-cycle result valid; ex_mem captures it.
REQ-015 stall_cnt_o  out  32  saturating count of cycles with stall_o[0]=1.
REQ-016 jump_cnt_o  out  16  saturating count of cycles with jump_o=1.

Function
REQ-017 stall_o, flush_o, jump_o, jump_addr_o and mc_done_o SHALL be combinational from the inputs and registered state (0-cycle latency); the FSM state and the counters SHALL be registered.
REQ-018 FSM states: RUN, MC_WAIT, MC_DONE; a down-counter mc_cnt (8 bits).
REQ-019 Per-cycle priority, highest first: mem_wait_i, then FSM state MC_WAIT/MC_DONE, then ex_jump_i, then ex_mc_start_i, then ld_use_i.
REQ-020 mem_wait_i=1: stall_o=5'b01111 and flush_o=5'b10000; jump_o=0; ex_jump_i, ex_mc_start_i and ld_use_i are ignored.
REQ-021 RUN with ex_jump_i=1: stall_o=0, flush_o=5'b00110, jump_o=1, jump_addr_o=ex_jump_addr_i.
REQ-022 RUN with ex_mc_start_i=1 and no jump: stall_o=5'b00111, flush_o=5'b01000; the next state is MC_WAIT with mc_cnt=MC_CYCLES-2.
REQ-023 MC_WAIT: stall_o=5'b00111 and flush_o=5'b01000 (unless REQ-020 applies); mc_cnt decrements every cycle, including while mem_wait_i=1.
REQ-024 MC_WAIT with mc_cnt=0: the next state is MC_DONE.
REQ-025 MC_DONE: mc_done_o=1.
- If mem_wait_i=0: stall_o=0, flush_o=0, and the next state is RUN.
- If mem_wait_i=1: stay in MC_DONE, keeping mc_done_o=1.
REQ-026 RUN with ld_use_i=1 only: stall_o=5'b00011, flush_o=5'b00100 (one bubble per asserted cycle).
REQ-027 RUN with no request: stall_o=0, flush_o=0, jump_o=0.
REQ-028 ex_jump_i, ex_mc_start_i and ld_use_i SHALL be ignored in MC_WAIT and MC_DONE.
REQ-029 A multi-cycle op therefore holds EX for exactly MC_CYCLES cycles when mem_wait_i=0 throughout, with mc_done_o in cycle T+MC_CYCLES (T = start cycle).
REQ-030 Both counters SHALL saturate at all-ones and never wrap.
REQ-031 jump_addr_o SHALL be 0 when jump_o=0.

Reset
REQ-032 With rst_i=1 at a clock edge, the state SHALL become RUN, mc_cnt=0 and both counters=0; reset mid-MC_WAIT abandons the op without a mc_done_o pulse.
REQ-033 While rst_i=1, the combinational outputs SHALL be: stall_o=0, flush_o=5'b11111, jump_o=0, jump_addr_o=0, mc_done_o=0.

Structure
REQ-034 The stall/flush bit indices, the state encodings and MC_CYCLES' default SHALL live in defines.v alongside the existing `ADDR_WIDTH, `WRITE_ENABLE and related macros.
REQ-035 The block is a single module with one natural sub-module, pipe_perf_cnt (a saturating counter instanced twice, width parameterised).

Verification
REQ-036 Reset-then-idle, all inputs 0 -> stall_o=0, flush_o=0, counters stay 0.
REQ-037 ex_jump_i=1 with ex_jump_addr_i=32'h0000_0100 for 1 cycle -> same cycle jump_o=1, jump_addr_o=32'h100, flush_o=5'b00110; jump_cnt_o=1 afterwards.
REQ-038 ex_mc_start_i pulse at T, MC_CYCLES=32, no mem_wait -> stall_o=5'b00111 for T..T+31, mc_done_o=1 only at T+32; stall_cnt_o=32.
REQ-039 As REQ-038 with mem_wait_i=1 over T+30..T+35 -> stall_o=5'b01111 in those cycles; mc_done_o=1 from T+32 through T+36; RUN at T+37.
REQ-040 ld_use_i=1 and ex_jump_i=1 in the same cycle -> jump wins: stall_o=0, flush_o=5'b00110.
REQ-041 rst_i=1 at T+10 of a multi-cycle op -> next cycle RUN, no mc_done_o, stall_cnt_o=0.
